// File: rtl/tdc_spi_arbiter.sv
// Two-requester arbiter in front of the TDC SPI master: grants per transaction,
// forwards the owner's start/MOSI/CS_END, drains between owners, revokes stalled owners.
module tdc_spi_arbiter #(
  parameter int          PRIORITY_MODE  = 0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  start_in,
  input  logic [15:0] mosi_in,
  input  logic [1:0]  cs_end_in,
  output logic [1:0]  gnt,
  output logic [1:0]  busy_out,
  output logic [7:0]  miso_out,
  output logic        spi_start,
  output logic [7:0]  spi_mosi,
  output logic        spi_cs_end,
  input  logic        spi_busy,
  input  logic [7:0]  spi_miso,
  output logic        timeout_flag,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        rr_ptr, rr_nx;
  logic [15:0] wd_cnt, wd_nx;
  logic [1:0]  gnt_nx;
  logic        start_nx, cs_end_nx, tflag_nx, perr_nx;
  logic [7:0]  mosi_nx;

  logic        own_req, own_start, own_cs_end;
  logic [7:0]  own_mosi;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fixed priority favours requester 0; round-robin hands a tie to the one not served last.
  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    if (r == 2'b10) return 1'b1;
    if (r == 2'b11 && PRIORITY_MODE != 0) return ~last;
    return 1'b0;
  endfunction

  assign own_req    = req[owner];
  assign own_start  = start_in[owner];
  assign own_cs_end = cs_end_in[owner];
  assign own_mosi   = owner ? mosi_in[15:8] : mosi_in[7:0];

  assign busy_out = {gnt[1] ? spi_busy : 1'b1, gnt[0] ? spi_busy : 1'b1};
  assign miso_out = spi_miso;

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    rr_nx     = rr_ptr;
    wd_nx     = wd_cnt;
    gnt_nx    = gnt;
    start_nx  = 1'b0;
    mosi_nx   = spi_mosi;
    cs_end_nx = spi_cs_end;
    tflag_nx  = 1'b0;
    perr_nx   = 1'b0;
    case (state)
      IDLE: begin
        gnt_nx    = 2'b00;
        cs_end_nx = 1'b1;
        if (req != 2'b00) begin
          owner_nx = pick_winner(req, rr_ptr);
          rr_nx    = owner_nx;
          gnt_nx   = owner_nx ? 2'b10 : 2'b01;
          wd_nx    = 16'd0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        // A start is only forwarded when the master is idle and not already being started.
        start_nx  = own_start & ~spi_busy & ~spi_start;
        perr_nx   = own_start & (spi_busy | spi_start);
        mosi_nx   = own_mosi;
        cs_end_nx = own_cs_end;
        if (own_start || spi_busy) begin
          wd_nx = 16'd0;
        end else begin
          wd_nx = sat_inc(wd_cnt);
          if (wd_cnt == TIMEOUT_CYCLES - 16'd1) begin
            tflag_nx = 1'b1;
            gnt_nx   = 2'b00;
            state_nx = DRAIN;
          end
        end
        if (!own_req) begin
          gnt_nx   = 2'b00;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        gnt_nx    = 2'b00;
        cs_end_nx = 1'b1;
        if (!spi_busy && !spi_start) state_nx = IDLE;
      end
      default: begin
        gnt_nx   = 2'b00;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      rr_ptr       <= 1'b0;
      wd_cnt       <= 16'd0;
      gnt          <= 2'b00;
      spi_start    <= 1'b0;
      spi_mosi     <= 8'h00;
      spi_cs_end   <= 1'b1;
      timeout_flag <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_nx;
      owner        <= owner_nx;
      rr_ptr       <= rr_nx;
      wd_cnt       <= wd_nx;
      gnt          <= gnt_nx;
      spi_start    <= start_nx;
      spi_mosi     <= mosi_nx;
      spi_cs_end   <= cs_end_nx;
      timeout_flag <= tflag_nx;
      proto_err    <= perr_nx;
    end
  end

endmodule

// File: tb/tb_tdc_spi_arbiter.sv
// Bench for tdc_spi_arbiter: a fixed-priority and a round-robin instance share stimulus
// and are checked against a transaction-level model of the grant rules.
module tb_tdc_spi_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, start_in, cs_end_in;
  logic [15:0] mosi_in;
  logic        spi_busy;
  logic [7:0]  spi_miso;

  logic [1:0][1:0] gnt_o, busy_o;
  logic [1:0][7:0] mosi_o, miso_o;
  logic [1:0]      sstart_o, cse_o, tf_o, pe_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdc_spi_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(16'(TO))) dut_fp (
    .clk(clk), .rst(rst), .req(req), .start_in(start_in), .mosi_in(mosi_in),
    .cs_end_in(cs_end_in), .gnt(gnt_o[0]), .busy_out(busy_o[0]), .miso_out(miso_o[0]),
    .spi_start(sstart_o[0]), .spi_mosi(mosi_o[0]), .spi_cs_end(cse_o[0]),
    .spi_busy(spi_busy), .spi_miso(spi_miso), .timeout_flag(tf_o[0]), .proto_err(pe_o[0]));

  tdc_spi_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(16'(TO))) dut_rr (
    .clk(clk), .rst(rst), .req(req), .start_in(start_in), .mosi_in(mosi_in),
    .cs_end_in(cs_end_in), .gnt(gnt_o[1]), .busy_out(busy_o[1]), .miso_out(miso_o[1]),
    .spi_start(sstart_o[1]), .spi_mosi(mosi_o[1]), .spi_cs_end(cse_o[1]),
    .spi_busy(spi_busy), .spi_miso(spi_miso), .timeout_flag(tf_o[1]), .proto_err(pe_o[1]));

  // Model: who owns the bus (-1 = nobody), whether the bus is draining, and the last winner.
  typedef struct {
    int       owner;
    bit       drain;
    bit       last;
    int       idle;
    bit       start;
    bit [7:0] mosi;
    bit       cs_end;
    bit       tflag;
    bit       perr;
  } m_t;

  m_t m[2];

  function automatic m_t mnext(input m_t c, input int mode);
    m_t n;
    bit st;
    n = c;
    n.tflag = 0;
    n.perr  = 0;
    if (rst) begin
      n.owner = -1; n.drain = 0; n.last = 0; n.idle = 0;
      n.start = 0; n.mosi = 8'h00; n.cs_end = 1;
      return n;
    end
    if (c.drain) begin
      n.start = 0; n.cs_end = 1;
      if (!spi_busy && !c.start) begin n.drain = 0; n.owner = -1; end
    end else if (c.owner < 0) begin
      n.start = 0; n.cs_end = 1;
      if (req != 2'b00) begin
        if (req == 2'b11) n.owner = (mode == 1) ? (c.last ? 0 : 1) : 0;
        else n.owner = req[1] ? 1 : 0;
        n.last = (n.owner == 1);
        n.idle = 0;
      end
    end else begin
      st       = start_in[c.owner];
      n.start  = st && !spi_busy && !c.start;
      n.perr   = st && (spi_busy || c.start);
      n.mosi   = mosi_in[8*c.owner +: 8];
      n.cs_end = cs_end_in[c.owner];
      if (st || spi_busy) n.idle = 0;
      else begin
        if (c.idle + 1 == TO) begin n.tflag = 1; n.drain = 1; end
        n.idle = (c.idle < 65535) ? c.idle + 1 : c.idle;
      end
      if (!req[c.owner]) n.drain = 1;
    end
    return n;
  endfunction

  function automatic logic [1:0] mgnt(input m_t c);
    if (c.owner < 0 || c.drain) return 2'b00;
    return (c.owner == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] mbusy(input m_t c);
    logic [1:0] g;
    g = mgnt(c);
    return {g[1] ? spi_busy : 1'b1, g[0] ? spi_busy : 1'b1};
  endfunction

  task automatic step();
    m_t n0, n1;
    n0 = mnext(m[0], 0);
    n1 = mnext(m[1], 1);
    @(posedge clk);
    m[0] = n0;
    m[1] = n1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; step(); step();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({gnt_o[i], sstart_o[i], mosi_o[i], cse_o[i], tf_o[i], pe_o[i], busy_o[i]} !==
          {2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b11}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got gnt=%b start=%b mosi=%h cs=%b tf=%b pe=%b busy=%b want 00 0 00 1 0 0 11",
                 i, gnt_o[i], sstart_o[i], mosi_o[i], cse_o[i], tf_o[i], pe_o[i], busy_o[i]);
      end
    end
  endtask

  task automatic test_basic();
    req = 2'b01; step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (gnt_o[i] !== 2'b01) begin n_fail++; $display("FAIL basic_gnt[%0d]: got %b want 01", i, gnt_o[i]); end
    end
    start_in = 2'b01; mosi_in = 16'h00A5; step();
    n_cmp++;
    if ({sstart_o[0], mosi_o[0], cse_o[0]} !== {1'b1, 8'hA5, 1'b1}) begin
      n_fail++; $display("FAIL basic_fwd: got start=%b mosi=%h cs=%b want 1 a5 1", sstart_o[0], mosi_o[0], cse_o[0]);
    end
    start_in = 2'b00; spi_busy = 1; step();
    n_cmp++;
    if ({sstart_o[0], busy_o[0]} !== {1'b0, 2'b11}) begin
      n_fail++; $display("FAIL basic_busy1: got start=%b busy=%b want 0 11", sstart_o[0], busy_o[0]);
    end
    spi_busy = 0; step();
    n_cmp++;
    if (busy_o[0] !== 2'b10) begin n_fail++; $display("FAIL basic_busy0: got %b want 10", busy_o[0]); end
    req = 2'b00; spi_busy = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) spi_busy = 0;
      step();
      n_cmp++;
      if ({gnt_o[0], cse_o[0], sstart_o[0]} !== {2'b00, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL basic_drain%0d: got gnt=%b cs=%b start=%b want 00 1 0", k, gnt_o[0], cse_o[0], sstart_o[0]);
      end
    end
    req = 2'b01; step();
    n_cmp++;
    if (gnt_o[0] !== 2'b01) begin n_fail++; $display("FAIL basic_regrant: got %b want 01", gnt_o[0]); end
    req = 2'b00; step(); step();
  endtask

  task automatic test_fixed_priority();
    int zeros;
    bit got;
    req = 2'b11; step();
    n_cmp++;
    if ({gnt_o[0], busy_o[0][1]} !== {2'b01, 1'b1}) begin
      n_fail++; $display("FAIL fp_tie: got gnt=%b busy1=%b want 01 1", gnt_o[0], busy_o[0][1]);
    end
    n_cmp++;
    if (gnt_o[1] !== mgnt(m[1])) begin n_fail++; $display("FAIL rr_first_tie: got %b want %b", gnt_o[1], mgnt(m[1])); end
    step();
    req = 2'b10;
    zeros = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (gnt_o[0] == 2'b10) got = 1;
      else if (gnt_o[0] == 2'b00) zeros++;
    end
    n_cmp++;
    if (!got || zeros < 2) begin
      n_fail++; $display("FAIL fp_handover: got granted=%0d zero_cycles=%0d want 1 and >=2", got, zeros);
    end
    req = 2'b00; step(); step(); step();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    int k;
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      k = 0;
      while (gnt_o[1] == 2'b00 && k < 10) begin step(); k++; end
      n_cmp++;
      if (gnt_o[1] !== order[t]) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", t, gnt_o[1], order[t]); end
      n_cmp++;
      if (gnt_o[0] !== mgnt(m[0])) begin n_fail++; $display("FAIL rr_fp_side%0d: got %b want %b", t, gnt_o[0], mgnt(m[0])); end
      req = (gnt_o[1] == 2'b01) ? 2'b10 : 2'b01;
      step();
      req = 2'b11;
    end
    req = 2'b00; step(); step(); step(); step();
  endtask

  task automatic test_timeout();
    req = 2'b01; step();
    req = 2'b11;
    for (int k = 0; k < TO - 1; k++) step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({gnt_o[i], tf_o[i]} !== {2'b01, 1'b0}) begin
        n_fail++; $display("FAIL to_early[%0d]: got gnt=%b tf=%b want 01 0", i, gnt_o[i], tf_o[i]);
      end
    end
    step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({gnt_o[i], tf_o[i]} !== {2'b00, 1'b1}) begin
        n_fail++; $display("FAIL to_fire[%0d]: got gnt=%b tf=%b want 00 1", i, gnt_o[i], tf_o[i]);
      end
    end
    req = 2'b10; step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({gnt_o[i], tf_o[i]} !== {2'b00, 1'b0}) begin
        n_fail++; $display("FAIL to_drain[%0d]: got gnt=%b tf=%b want 00 0", i, gnt_o[i], tf_o[i]);
      end
    end
    step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (gnt_o[i] !== 2'b10) begin n_fail++; $display("FAIL to_pending[%0d]: got %b want 10", i, gnt_o[i]); end
    end
    req = 2'b00; step(); step(); step();
  endtask

  task automatic test_proto_err();
    req = 2'b01; step();
    spi_busy = 1; start_in = 2'b01; step();
    n_cmp++;
    if ({sstart_o[0], pe_o[0]} !== 2'b01) begin
      n_fail++; $display("FAIL pe_busy: got start=%b pe=%b want 0 1", sstart_o[0], pe_o[0]);
    end
    start_in = 2'b00; step();
    n_cmp++;
    if (pe_o[0] !== 1'b0) begin n_fail++; $display("FAIL pe_pulse: got %b want 0", pe_o[0]); end
    spi_busy = 0; start_in = 2'b01; mosi_in = 16'h003C; step();
    n_cmp++;
    if ({sstart_o[0], mosi_o[0], pe_o[0]} !== {1'b1, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL pe_after: got start=%b mosi=%h pe=%b want 1 3c 0", sstart_o[0], mosi_o[0], pe_o[0]);
    end
    step();
    n_cmp++;
    if ({sstart_o[0], pe_o[0]} !== 2'b01) begin
      n_fail++; $display("FAIL pe_b2b: got start=%b pe=%b want 0 1", sstart_o[0], pe_o[0]);
    end
    start_in = 2'b10; step();
    n_cmp++;
    if ({sstart_o[0], pe_o[0], busy_o[0][1]} !== 3'b001) begin
      n_fail++; $display("FAIL pe_nonowner: got start=%b pe=%b busy1=%b want 0 0 1", sstart_o[0], pe_o[0], busy_o[0][1]);
    end
    start_in = 2'b00;
  endtask

  task automatic test_reset_mid();
    spi_busy = 1; step();
    rst = 1; step();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({gnt_o[i], cse_o[i], sstart_o[i]} !== {2'b00, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL rst_mid[%0d]: got gnt=%b cs=%b start=%b want 00 1 0", i, gnt_o[i], cse_o[i], sstart_o[i]);
      end
    end
    step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (gnt_o[i] !== 2'b01) begin n_fail++; $display("FAIL rst_regrant[%0d]: got %b want 01", i, gnt_o[i]); end
    end
    req = 2'b00; spi_busy = 0; step(); step(); step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      if (c < 350) begin
        start_in = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        if ($urandom_range(0, 3) == 0) spi_busy = ~spi_busy;
      end else begin
        start_in = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        spi_busy = ($urandom_range(0, 19) == 0);
      end
      mosi_in   = 16'($urandom);
      cs_end_in = 2'($urandom_range(0, 3));
      spi_miso  = 8'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({gnt_o[i], sstart_o[i], mosi_o[i], cse_o[i], tf_o[i], pe_o[i], busy_o[i], miso_o[i]} !==
            {mgnt(m[i]), m[i].start, m[i].mosi, m[i].cs_end, m[i].tflag, m[i].perr, mbusy(m[i]), spi_miso}) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: got gnt=%b st=%b mosi=%h cs=%b tf=%b pe=%b busy=%b miso=%h want %b %b %h %b %b %b %b %h",
                   i, c, gnt_o[i], sstart_o[i], mosi_o[i], cse_o[i], tf_o[i], pe_o[i], busy_o[i], miso_o[i],
                   mgnt(m[i]), m[i].start, m[i].mosi, m[i].cs_end, m[i].tflag, m[i].perr, mbusy(m[i]), spi_miso);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got stall want completion");
    $fatal(1);
  end

  initial begin
    rst = 1; req = 2'b00; start_in = 2'b00; mosi_in = 16'h0000;
    cs_end_in = 2'b11; spi_busy = 0; spi_miso = 8'h00;
    test_reset();
    test_basic();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_spi_arbiter.md
Name: tdc_spi_arbiter

Overview:
Shares the single TDC SPI master between two requesters: requester 0 is the measurement sequencer (shot/read cycle) and requester 1 is the host configuration/register-access path.
- Grants the bus per transaction and muxes start/MOSI/CS_END to the SPI master.
- Returns per-requester busy, and broadcasts MISO to both requesters.
- Drains the bus cleanly between owners and revokes a stalled owner with a watchdog.
- Sits between the requester state machines and the SPI master, in the TDC clock domain.

Parameters:
PRIORITY_MODE, 0, 0 = fixed priority (requester 0 wins), 1 = round-robin.
TIMEOUT_CYCLES, 16'd2000, number of idle owner cycles before the grant is revoked.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  2  per-requester bus request, held high for the whole transaction
start_in  in  2  per-requester SPI start pulse
mosi_in  in  16  {mosi1[7:0], mosi0[7:0]}
cs_end_in  in  2  per-requester CS_END (1 = release CS after the current byte)
gnt  out  2  one-hot grant, 2'b00 when no owner
busy_out  out  2  per-requester busy: spi_busy when granted, else 1
miso_out  out  8  spi_miso broadcast, unregistered
spi_start  out  1  start to the SPI master
spi_mosi  out  8  byte to the SPI master
spi_cs_end  out  1  CS_END to the SPI master
spi_busy  in  1  SPI master busy
spi_miso  in  8  byte from the SPI master
timeout_flag  out  1  one-cycle pulse on watchdog revoke
proto_err  out  1  one-cycle pulse when an owner start is dropped

Behaviour:
- All outputs are registered except busy_out and miso_out, which are combinational.
- Reset values: gnt = 0, spi_start = 0, spi_mosi = 8'h00, spi_cs_end = 1, timeout_flag = 0, proto_err = 0, state = IDLE, rr_ptr = 0, wd_cnt = 0.
- Reset mid-transaction: all of the above apply on the next edge regardless of spi_busy; the SPI master is not waited on.

State IDLE:
- spi_cs_end = 1 and spi_start = 0.
- If req != 0, select a winner and register gnt. Grant latency is 1 cycle from req to gnt.
- Fixed priority: requester 0 wins whenever req[0] = 1.
- Round-robin: on a tie the requester != rr_ptr wins. rr_ptr is set to the winner on each grant.
- Transition to GRANT.

State GRANT, with owner o:
- spi_start <= start_in[o] & ~spi_busy & ~spi_start.
- spi_mosi <= mosi_in[o].
- spi_cs_end <= cs_end_in[o].
- Forwarding latency is 1 cycle.
- If start_in[o] = 1 while spi_busy = 1 or spi_start = 1, the start is dropped and proto_err pulses the next cycle.
- start_in from the non-owner is ignored silently.
- The non-owner's busy_out stays 1.
- If req[o] = 0 (including on the very cycle gnt rises), transition to DRAIN.

Watchdog (active in GRANT):
- wd_cnt clears when start_in[o] = 1 or spi_busy = 1; otherwise it increments.
- When wd_cnt = TIMEOUT_CYCLES-1: gnt <= 0, timeout_flag pulses, transition to DRAIN.
- The counter saturates and never wraps.

State DRAIN:
- gnt = 0, spi_start = 0, spi_cs_end = 1.
- Stay until spi_busy = 0 and spi_start = 0, then transition to IDLE.
- This guarantees at least one IDLE cycle between consecutive grants, so gnt changing owner always shows 2'b00 for 2 or more cycles.
- A requester still holding req after a timeout is re-arbitrated normally in IDLE.

Arithmetic:
- wd_cnt is 16 bits; TIMEOUT_CYCLES must be >= 2.

Test Plan:
1. Reset, then req = 2'b01; on cycle 1 gnt = 2'b01. start_in[0] pulse with mosi0 = 8'hA5 -> next cycle spi_start = 1, spi_mosi = 8'hA5. Drop req -> DRAIN, then IDLE once spi_busy = 0; spi_cs_end = 1 throughout.
2. PRIORITY_MODE = 0, req = 2'b11 in IDLE -> gnt = 2'b01. Release -> gnt = 2'b00 for 2 or more cycles -> gnt = 2'b10. busy_out[1] = 1 while requester 0 owns the bus.
3. PRIORITY_MODE = 1, req = 2'b11 held through four transactions -> grant order 01, 10, 01, 10.
4. TIMEOUT_CYCLES = 16, owner 0 idle with spi_busy = 0 -> on the 16th idle cycle gnt = 0 and timeout_flag pulses once. Pending req[1] = 1 is granted after DRAIN.
5. Owner start_in pulse while spi_busy = 1 -> spi_start stays 0 and proto_err pulses 1 cycle. The next start after busy falls is forwarded.
6. rst asserted mid-byte (spi_busy = 1, gnt = 01) -> next edge gnt = 0, spi_cs_end = 1, state IDLE. Re-request is granted in 1 cycle.
